// File: rtl/mlp_pkg.sv
// Shared definitions for the mandelbrot frame sequencer: state encoding,
// job payload widths, default raster size and a saturating increment helper.
package mlp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } seq_state_t;

  localparam int TIME_W    = 16;
  localparam int ALPHA_W   = 8;
  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mlp_raster_cnt.sv
// Pixel raster walker: x runs 0..H_RES-1 within a line, y steps at end of line.
// last_pixel flags the bottom-right pixel so the sequencer knows when to drain.
module mlp_raster_cnt #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_pixel
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/mlp_frame_seq.sv
// Frame sequencer: walks the raster issuing one job per pixel, tracks jobs in
// flight and reports busy/done. Optional macro FRAME_PERF_EN adds frame_cycles.
module mlp_frame_seq
  import mlp_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int COORD_W = 10,
  parameter int OUT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start_pulse,
  input  logic               frame_auto,
  input  logic               ps_override,
  input  logic [15:0]        time_val,
  input  logic [7:0]         morph_alpha,
  input  logic               vsync_tick,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [COORD_W-1:0] job_x,
  output logic [COORD_W-1:0] job_y,
  output logic [15:0]        job_time,
  output logic [7:0]         job_alpha,
  input  logic               res_valid,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               seq_err
`ifdef FRAME_PERF_EN
  ,
  output logic [31:0]        frame_cycles
`endif
);

  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  seq_state_t          state;
  logic [OUT_W-1:0]    out_cnt;
  logic [OUT_W-1:0]    out_next;
  logic [TIME_W-1:0]   frame_cnt;
  logic                pending;
  logic                start_req;
  logic                accept;
  logic                res_ok;
  logic                last_pixel;
  logic                raster_clear;

  assign start_req    = frame_start_pulse | (frame_auto & vsync_tick);
  assign accept       = job_valid & job_ready;
  assign res_ok       = res_valid && (out_cnt != '0);
  assign raster_clear = (state == IDLE);

  mlp_raster_cnt #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .COORD_W (COORD_W)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (raster_clear),
    .advance    (accept),
    .x          (job_x),
    .y          (job_y),
    .last_pixel (last_pixel)
  );

  // NOTE: out_next gets a default before the case so no latch is inferred.
  always_comb begin
    out_next = out_cnt;
    case ({accept, res_ok})
      2'b10:   out_next = out_cnt + OUT_W'(1);
      2'b01:   out_next = out_cnt - OUT_W'(1);
      default: out_next = out_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_cnt    <= '0;
      frame_cnt  <= '0;
      pending    <= 1'b0;
      job_valid  <= 1'b0;
      job_time   <= '0;
      job_alpha  <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      out_cnt    <= out_next;
      frame_done <= 1'b0;
      if (state != IDLE && start_req) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start_req || pending) begin
            state      <= ISSUE;
            pending    <= 1'b0;
            seq_err    <= 1'b0;
            job_valid  <= 1'b1;
            frame_busy <= 1'b1;
            job_time   <= ps_override ? time_val : frame_cnt;
            job_alpha  <= ps_override ? morph_alpha : '0;
          end
        end
        ISSUE: begin
          if (accept && last_pixel) begin
            state     <= DRAIN;
            job_valid <= 1'b0;
          end else begin
            // Throttle when the in-flight window is full; a completion reopens it.
            job_valid <= (out_next != OUT_MAX);
          end
        end
        DRAIN: begin
          if (out_cnt == '0) begin
            state      <= DONE;
            frame_busy <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          frame_cnt <= frame_cnt + TIME_W'(1);
        end
        default: state <= IDLE;
      endcase

      // Error set wins over the clear at frame start in the same cycle.
      if ((res_valid && out_cnt == '0) || (accept && out_cnt == OUT_MAX))
        seq_err <= 1'b1;
    end
  end

`ifdef FRAME_PERF_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else begin
      case (state)
        IDLE:         cyc_cnt <= '0;
        ISSUE, DRAIN: cyc_cnt <= sat_inc32(cyc_cnt);
        DONE:         frame_cycles <= sat_inc32(cyc_cnt);
        default:      cyc_cnt <= cyc_cnt;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mlp_frame_seq.sv
// Scoreboard bench for mlp_frame_seq on a 4x2 raster with a 3-deep in-flight
// window; expected jobs are queued at stimulus time and popped by a monitor.
module tb_mlp_frame_seq;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int CW = 10;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start_pulse = 1'b0;
  logic          frame_auto = 1'b0;
  logic          ps_override = 1'b0;
  logic [15:0]   time_val = '0;
  logic [7:0]    morph_alpha = '0;
  logic          vsync_tick = 1'b0;
  logic          job_valid;
  logic          job_ready = 1'b1;
  logic [CW-1:0] job_x;
  logic [CW-1:0] job_y;
  logic [15:0]   job_time;
  logic [7:0]    job_alpha;
  logic          res_valid = 1'b0;
  logic          frame_busy;
  logic          frame_done;
  logic          seq_err;
`ifdef FRAME_PERF_EN
  logic [31:0]   frame_cycles;
`endif

  mlp_frame_seq #(.H_RES(H), .V_RES(V), .COORD_W(CW), .OUT_W(OW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_start_pulse (frame_start_pulse),
    .frame_auto        (frame_auto),
    .ps_override       (ps_override),
    .time_val          (time_val),
    .morph_alpha       (morph_alpha),
    .vsync_tick        (vsync_tick),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_x             (job_x),
    .job_y             (job_y),
    .job_time          (job_time),
    .job_alpha         (job_alpha),
    .res_valid         (res_valid),
    .frame_busy        (frame_busy),
    .frame_done        (frame_done),
    .seq_err           (seq_err)
`ifdef FRAME_PERF_EN
    ,
    .frame_cycles      (frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [15:0]   t;
    logic [7:0]    a;
  } job_t;

  job_t        exp_q[$];
  int          due_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          last_res = 0;
  bit          hold_v = 0;
  logic [43:0] hold_p = '0;
  bit          res_auto = 1;
  bit          force_req = 0;
  bit          rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ready driver: constant 1 or a coin toss per cycle.
  always @(posedge clk) begin
    #1;
    job_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Result responder: one completion three cycles after each accept, or on demand.
  always @(posedge clk) begin
    #1;
    res_valid = 1'b0;
    if (force_req) begin
      res_valid = 1'b1;
      force_req = 0;
      if (due_q.size() > 0) void'(due_q.pop_front());
    end else if (res_auto && due_q.size() > 0 && due_q[0] <= cyc) begin
      res_valid = 1'b1;
      void'(due_q.pop_front());
    end
  end

  // Monitor: compares accepted jobs against the scoreboard and watches handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v && !job_valid) check("valid_dropped", 0, 1);
      if (job_valid) begin
        check("busy_with_valid", frame_busy, 1);
        if (hold_v) check("payload_stable", {job_x, job_y, job_time, job_alpha}, hold_p);
        if (job_ready) begin
          acc_cnt++;
          due_q.push_back(cyc + 3);
          hold_v = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_job actual=(%0d,%0d) required=none", job_x, job_y);
          end else begin
            job_t e;
            e = exp_q.pop_front();
            check("job", {job_x, job_y, job_time, job_alpha}, {e.x, e.y, e.t, e.a});
          end
        end else begin
          hold_v = 1;
          hold_p = {job_x, job_y, job_time, job_alpha};
        end
      end else begin
        hold_v = 0;
      end
      if (res_valid) last_res = cyc;
      if (frame_done) begin
        done_cnt++;
        check("done_busy_low", frame_busy, 0);
        check("done_latency", cyc - last_res, 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] t, input logic [7:0] a);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        job_t j;
        j.x = CW'(x);
        j.y = CW'(y);
        j.t = t;
        j.a = a;
        exp_q.push_back(j);
      end
  endtask

  task automatic pulse_start();
    step();
    frame_start_pulse = 1'b1;
    step();
    frame_start_pulse = 1'b0;
  endtask

  task automatic start_frame();
    pulse_start();
    @(negedge clk);
    check("start_busy", frame_busy, 1);
    check("start_valid", job_valid, 1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 3000 && done_cnt < n; i++) @(negedge clk);
    check("done_count", done_cnt, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, job_valid, 0);
    check({tag, "_busy"}, frame_busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_err"}, seq_err, 0);
    check({tag, "_xy"}, {job_x, job_y}, 0);
    check({tag, "_time_alpha"}, {job_time, job_alpha}, 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // Internal frame counter supplies job_time over three frames.
    ps_override = 1'b0;
    for (int f = 0; f < 3; f++) begin
      push_frame(16'(f), 8'h00);
      start_frame();
      wait_done(f + 1);
    end

    // PS override: snapshot is taken at frame start, mid-frame changes ignored.
    ps_override = 1'b1;
    time_val    = 16'h1234;
    morph_alpha = 8'h80;
    push_frame(16'h1234, 8'h80);
    start_frame();
    repeat (3) @(negedge clk);
    time_val    = 16'hBEEF;
    morph_alpha = 8'h01;
    wait_done(4);

    // Random backpressure.
    rand_ready  = 1;
    time_val    = 16'h5555;
    morph_alpha = 8'h11;
    push_frame(16'h5555, 8'h11);
    start_frame();
    wait_done(5);
    rand_ready = 0;

    // Extra starts while busy coalesce into exactly one follow-on frame.
    ps_override = 1'b0;
    push_frame(16'd5, 8'h00);
    push_frame(16'd6, 8'h00);
    start_frame();
    repeat (3) pulse_start();
    wait_done(7);
    repeat (40) @(negedge clk);
    check("coalesce_done_count", done_cnt, 7);
    check("coalesce_idle", frame_busy, 0);
    check("coalesce_queue_empty", exp_q.size(), 0);

    // In-flight window: 3 accepts then stall until a completion arrives.
    ps_override = 1'b1;
    time_val    = 16'h0A0A;
    morph_alpha = 8'h22;
    res_auto    = 0;
    base        = acc_cnt;
    push_frame(16'h0A0A, 8'h22);
    start_frame();
    repeat (10) @(negedge clk);
    check("stall_accepts", acc_cnt - base, 3);
    check("stall_valid_low", job_valid, 0);
    force_req = 1;
    repeat (6) @(negedge clk);
    check("resume_accepts", acc_cnt - base, 4);
    check("resume_valid_low", job_valid, 0);
    res_auto = 1;
    wait_done(8);
    check("stall_no_err", seq_err, 0);

    // Spurious completion in IDLE raises seq_err; next start clears it.
    repeat (3) @(negedge clk);
    force_req = 1;
    repeat (3) @(negedge clk);
    check("spurious_err", seq_err, 1);
    time_val    = 16'h00C3;
    morph_alpha = 8'h3C;
    push_frame(16'h00C3, 8'h3C);
    start_frame();
    check("err_cleared", seq_err, 0);
    wait_done(9);

    // Asynchronous reset mid-ISSUE aborts the frame without frame_done.
    ps_override = 1'b0;
    base        = acc_cnt;
    push_frame(16'd9, 8'h00);
    start_frame();
    for (int i = 0; i < 100 && acc_cnt < base + 2; i++) @(negedge clk);
    check("pre_reset_busy", frame_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    due_q.delete();
    hold_v = 0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 9);
    rst_n = 1'b1;

    // Auto mode: vsync_tick starts a clean frame from pixel (0,0), counter restarted.
    frame_auto = 1'b1;
    push_frame(16'd0, 8'h00);
    step();
    vsync_tick = 1'b1;
    step();
    vsync_tick = 1'b0;
    @(negedge clk);
    check("auto_busy", frame_busy, 1);
    check("auto_first_xy", {job_x, job_y}, 0);
    wait_done(10);
    frame_auto = 1'b0;
    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_frame_seq.md
Name: mlp_frame_seq

Overview:
Frame sequencer between the AXI-Lite control slave and the mlp_core array inside mandelbrot_top. It consumes frame_start_pulse, frame_auto, ps_override, time_val and morph_alpha, and walks the pixel raster. For each pixel it issues one job (x, y, time, alpha) over a valid/ready handshake and counts per-pixel completions. It produces the frame_busy level and the frame_done pulse that the control slave reports in its STATUS register.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
COORD_W, 10, width of job_x/job_y; must hold H_RES-1 and V_RES-1
OUT_W, 6, width of outstanding-job counter; max in flight = 2^OUT_W-1

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
frame_start_pulse  in  1  one-cycle PS trigger
frame_auto  in  1  1 = vsync_tick also triggers frames
ps_override  in  1  1 = use PS time/alpha; 0 = internal frame counter
time_val  in  16  PS frame time
morph_alpha  in  8  PS blend factor
vsync_tick  in  1  one-cycle display frame tick
job_valid  out  1  job offered to core array
job_ready  in  1  core array accepts job
job_x  out  COORD_W  pixel column
job_y  out  COORD_W  pixel row
job_time  out  16  frame time for this frame
job_alpha  out  8  blend factor for this frame
res_valid  in  1  one pixel completed (one pulse per pixel)
frame_busy  out  1  frame in progress
frame_done  out  1  one-cycle completion pulse
seq_err  out  1  sticky: res_valid seen with zero outstanding, or outstanding overflow attempt

Behaviour:
- Reset values: all outputs 0, state IDLE, internal frame counter 0, pending flag 0.
- start_req = frame_start_pulse | (frame_auto & vsync_tick).
- States:
  - IDLE: on start_req or pending, snapshot time/alpha, clear pending, x=y=0, go to ISSUE.
    - Snapshot rule: ps_override=1 takes time_val/morph_alpha; ps_override=0 takes the frame counter and alpha 0.
  - ISSUE: job_valid=1. Payload is stable while job_valid && !job_ready. On accept, x++.
    - At x=H_RES-1: x=0, y++.
    - Accepting pixel (H_RES-1, V_RES-1) moves to DRAIN with job_valid=0 the next cycle.
    - If outstanding = 2^OUT_W-1, job_valid is held low (stall) until a completion arrives.
  - DRAIN: wait until outstanding=0, then go to DONE.
  - DONE: exactly one cycle. frame_done=1, frame_busy=0, frame counter +1 (wraps at 16 bits). Next state is IDLE; the pending flag is then serviced from IDLE, one cycle later.
- frame_busy = 1 in ISSUE and DRAIN only.
- Latency: start_req in cycle N gives frame_busy=1 and job_valid=1 in N+1.
- Outstanding counter:
  - +1 on job accept, -1 on res_valid; both in the same cycle leaves it unchanged.
  - res_valid at 0 is ignored and sets seq_err.
- start_req while not IDLE sets pending. Multiple requests coalesce to one pending frame.
- start_req in the DONE cycle also sets pending.
- seq_err clears only when a new frame starts from IDLE.
- Asynchronous reset mid-frame aborts immediately: all state cleared, no frame_done emitted.

Optional Feature:
FRAME_PERF_EN
- Defined: extra output frame_cycles[31:0], reset 0.
  - An internal counter runs from the first ISSUE cycle through the DONE cycle inclusive and saturates at 0xFFFFFFFF.
  - frame_cycles is loaded from it in DONE and holds until the next DONE.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package mlp_pkg:
  - state encoding localparams (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
  - job payload field widths (time 16, alpha 8)
  - default H_RES/V_RES
- One natural sub-module, mlp_raster_cnt: x/y counter with advance input, clear input and last_pixel flag.

Test Plan:
- H_RES=4, V_RES=2, job_ready=1, res_valid echoed 3 cycles after each accept → 8 jobs in raster order (0,0)…(3,1); frame_done once, 1 cycle after last res_valid is counted; frame_busy high from start+1 until DONE.
- ps_override=1, time_val=0x1234, alpha=0x80; change time_val mid-frame → every job carries 0x1234/0x80. ps_override=0 over 3 frames → job_time 0, 1, 2.
- job_ready toggled randomly → payload never changes while valid && !ready; no pixel skipped or duplicated.
- Three frame_start_pulse during a busy frame → exactly one extra frame follows; total frame_done pulses = 2.
- Hold res_valid low, OUT_W=2 → job_valid drops after 3 accepts; a res_valid pulse resumes issue. Spurious res_valid in IDLE → seq_err=1, cleared at next start.
- Assert rst_n low mid-ISSUE → all outputs 0 asynchronously; after release, frame_auto with vsync_tick starts a clean frame at (0,0).
